bcd_seq_adder: RTL



---
 rtl/bcd_seq_adder_pkg.sv | 9 +
 rtl/bcd_seq_adder_digit_add.sv | 17 +
 rtl/bcd_seq_adder.sv | 84 ++++++++
 3 files changed

// File: rtl/bcd_seq_adder_pkg.sv
// bcd_pkg: shared FSM states, BCD constants and digit helpers for the digit-serial BCD adder.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction
endpackage

// File: rtl/bcd_seq_adder_digit_add.sv
// bcd_digit_add: single-digit combinational BCD adder with decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    output logic [3:0] s_d,
    output logic       cout
);
    logic [4:0] raw;
    always_comb begin
        raw  = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cin};
        cout = raw > {1'b0, BCD_MAX};
        s_d  = cout ? raw[3:0] + BCD_CORR : raw[3:0];
    end
endmodule

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic              ready,
    output logic              done,
    output logic [4*DIGITS-1:0] sum,
    output logic              cout
    ,
    output logic              err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, sum_q, sum_d;
    logic [IW-1:0]  idx_q;
    logic           sub_q, carry_q, cout_q, err_q;
    logic [3:0]     b_eff, s_d;
    logic           c_d, bad, last;
    bcd_digit_add u_add (
        .a_d  (a_q[3:0]),
        .b_d  (b_eff),
        .cin  (carry_q),
        .s_d  (s_d),
        .cout (c_d)
    );
    always_comb begin
        b_eff = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];
        last  = idx_q == IW'(DIGITS - 1);
        bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (a[4*i +: 4] > BCD_MAX) | (b[4*i +: 4] > BCD_MAX);
        sum_d = sum_q;
        for (int i = 0; i < DIGITS; i++)
            if (idx_q == IW'(i)) sum_d[4*i +: 4] = err_q ? 4'd0 : s_d;
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? (last ? DONE : RUN)  : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                a_q     <= a;
                b_q     <= b;
                sub_q   <= sub;
                carry_q <= sub;
                idx_q   <= '0;
                sum_q   <= '0;
                err_q   <= bad;
            end else if (state_q == RUN) begin
                // operands shift so the adder always sees the current digit in [3:0]
                a_q     <= a_q >> 4;
                b_q     <= b_q >> 4;
                carry_q <= c_d;
                idx_q   <= idx_q + 1'b1;
                sum_q   <= sum_d;
                if (last) cout_q <= c_d & ~err_q;
            end
        end
    end
    assign ready = state_q == IDLE;
    assign done  = state_q == DONE;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign err   = err_q;
endmodule
